// File: rtl/mips_dmem_unit.sv
// MEMORY-stage data memory: byte-addressed little-endian RAM behind a valid/ready port.
// Define MIPS_DMEM_SUBWORD_EN to honour req_size/req_signed (LB/LBU/LH/LHU/SB/SH).
module mips_dmem_unit #(
  parameter int DMEM_BYTES = 128,
  parameter int ACCESS_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DMEM_BYTES);
  localparam int CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept, commit;

  logic            we_q;
  logic [31:0]     addr_q, wdata_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic            err_q;

  logic            cur_we, cur_err;
  logic [31:0]     cur_addr, cur_wdata;
  logic [1:0]      cur_size;
  logic [AW-1:0]   cur_idx, cur_hbase, cur_wbase;
  logic [AW-1:0]   idx_q, hbase_q, wbase_q;

  logic [7:0]      mem [DMEM_BYTES];
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v, load_v;

  function automatic logic access_err(input logic [31:0] a, input logic [1:0] sz);
    logic mis;
    case (sz)
      2'd0:    mis = 1'b0;
      2'd1:    mis = a[0];
      2'd2:    mis = |a[1:0];
      default: mis = 1'b1;
    endcase
    return (a >= 32'(DMEM_BYTES)) || mis;
  endfunction

  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

`ifdef MIPS_DMEM_SUBWORD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q   <= 2'd2;
      signed_q <= 1'b0;
    end else if (accept) begin
      size_q   <= req_size;
      signed_q <= req_signed;
    end
  end
  assign cur_size = (state == IDLE) ? req_size : size_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{req_size, req_signed};
  assign size_q     = 2'd2;
  assign signed_q   = 1'b0;
  assign cur_size   = 2'd2;
`endif

  // cnt holds the number of WAIT cycles still to spend; the last one hands over to RESP.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (ACCESS_LAT == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // With a one-cycle latency the commit edge is the accept edge, so the live request is used.
  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign cur_err   = access_err(cur_addr, cur_size);
  assign cur_idx   = cur_addr[AW-1:0];
  assign cur_hbase = cur_idx & ~AW'(1);
  assign cur_wbase = cur_idx & ~AW'(3);

  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_err) begin
      case (cur_size)
        2'd0: mem[cur_idx] <= cur_wdata[7:0];
        2'd1: begin
          mem[cur_hbase]          <= cur_wdata[7:0];
          mem[cur_hbase | AW'(1)] <= cur_wdata[15:8];
        end
        default: begin
          for (int i = 0; i < 4; i++) begin
            mem[cur_wbase | AW'(i)] <= cur_wdata[8*i +: 8];
          end
        end
      endcase
    end
  end

  assign err_q   = access_err(addr_q, size_q);
  assign idx_q   = addr_q[AW-1:0];
  assign hbase_q = idx_q & ~AW'(1);
  assign wbase_q = idx_q & ~AW'(3);

  always_comb begin
    byte_v = mem[idx_q];
    half_v = {mem[hbase_q | AW'(1)], mem[hbase_q]};
    word_v = {mem[wbase_q | AW'(3)], mem[wbase_q | AW'(2)],
              mem[wbase_q | AW'(1)], mem[wbase_q]};
    case (size_q)
      2'd0:    load_v = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      2'd1:    load_v = signed_q ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      default: load_v = word_v;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = ((state == RESP) && !we_q && !err_q) ? load_v : 32'd0;

endmodule

// File: tb/tb_mips_dmem_unit.sv
// Bench for mips_dmem_unit: array-based reference model checked every cycle on a
// two-cycle-latency instance, plus directed literal checks (incl. a one-cycle instance).
module tb_mips_dmem_unit;

  localparam int LAT   = 2;
  localparam int BYTES = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'd2;
  logic        req_signed = 1'b0;

  logic        a_ready, a_rsp_valid, a_err, a_busy;
  logic [31:0] a_rdata;
  logic        b_ready, b_rsp_valid, b_err, b_busy;
  logic [31:0] b_rdata;

  mips_dmem_unit #(.DMEM_BYTES(BYTES), .ACCESS_LAT(LAT)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signed(req_signed), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rdata), .rsp_err(a_err), .busy(a_busy));

  mips_dmem_unit #(.DMEM_BYTES(BYTES), .ACCESS_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signed(req_signed), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;
  bit sel = 1'b0;

  logic        c_ready, c_rsp_valid, c_err;
  logic [31:0] c_rdata;
  assign c_ready     = sel ? b_ready     : a_ready;
  assign c_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign c_err       = sel ? b_err       : a_err;
  assign c_rdata     = sel ? b_rdata     : a_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instance a) ----------------
  logic [7:0]  ref_mem [BYTES];
  bit          m_busy = 1'b0;
  int          n = 0;
  int          m_e = 0;
  bit          exp_rsp = 1'b0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_data = '0;
  bit          p_we, p_sgn;
  logic [31:0] p_addr, p_wdata;
  int          p_size;

  task automatic model_complete();
    int sz, nb;
    bit sg, e;
    longint unsigned v;
`ifdef MIPS_DMEM_SUBWORD_EN
    sz = p_size;
    sg = p_sgn;
`else
    sz = 2;
    sg = 1'b0;
`endif
    e = (p_addr >= BYTES) || (sz == 3) || (sz == 2 && p_addr % 4 != 0) ||
        (sz == 1 && p_addr % 2 != 0);
    exp_rsp  = 1'b1;
    exp_err  = e;
    exp_data = '0;
    if (!e) begin
      nb = 1 << sz;
      if (p_we) begin
        for (int i = 0; i < nb; i++) ref_mem[p_addr + i] = 8'((p_wdata >> (8 * i)) & 32'hFF);
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v + (longint'(ref_mem[p_addr + i]) << (8 * i));
        if (sg && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        exp_data = v[31:0];
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      exp_rsp = 1'b0;
      exp_err = 1'b0;
      exp_data = '0;
    end else begin
      n++;
      exp_rsp = 1'b0;
      if (m_busy && n == m_e + LAT) m_busy = 1'b0;
      else if (!m_busy && req_valid) begin
        m_busy  = 1'b1;
        m_e     = n;
        p_we    = req_we;
        p_addr  = req_addr;
        p_wdata = req_wdata;
        p_size  = int'(req_size);
        p_sgn   = req_signed;
      end
      if (m_busy && n == m_e + LAT - 1) model_complete();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(a_ready), 32'(!m_busy));
      chk("busy", 32'(a_busy), 32'(m_busy));
      chk("rsp_valid", 32'(a_rsp_valid), 32'(exp_rsp));
      chk("rsp_rdata", a_rdata, exp_rsp ? exp_data : 32'd0);
      chk("rsp_err", 32'(a_err), 32'(exp_rsp && exp_err));
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit sg,
                        output logic [31:0] rd, output logic er, output int lat);
    int g;
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    req_size = sz; req_signed = sg;
    g = 0;
    while (!c_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!c_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (c_rsp_valid) begin
        rd = c_rdata;
        er = c_err;
        got = 1'b1;
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          acc_cyc [4];
  int          acc_n;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(a_ready), 32'd1);
    chk("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    for (int a = 0; a < BYTES; a += 4)
      access(1'b1, 32'(a), {8'hC0, 8'(a), 8'h5A, 8'(a)}, 2'd2, 1'b0, rd, er, lat);

    access(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd, er, lat);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_err", 32'(er), 32'd0);
    access(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_latency", 32'(lat), 32'd2);
    chk("lw_byte0", rd & 32'hFF, 32'hEF);

    access(1'b0, 32'h12, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    access(1'b1, 32'h80, 32'hFFFFFFFF, 2'd2, 1'b0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    access(1'b0, 32'h00, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("oor_nowrite", rd, 32'hC0005A00);

    // back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2;
    acc_n = 0;
    for (int c = 0; c < 9; c++) begin
      if (a_ready && acc_n < 4) begin
        acc_cyc[acc_n] = c;
        acc_n++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_count", 32'(acc_n), 32'd3);
    chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
    chk("b2b_acc1", 32'(acc_cyc[1]), 32'd3);
    chk("b2b_acc2", 32'(acc_cyc[2]), 32'd6);
    repeat (3) @(negedge clk);

    // reset aborts a pending store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    access(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("abort_keeps_old", rd, 32'hC0205A20);

`ifdef MIPS_DMEM_SUBWORD_EN
    access(1'b1, 32'h30, 32'h000000F0, 2'd2, 1'b0, rd, er, lat);
    access(1'b0, 32'h30, 32'h0, 2'd0, 1'b1, rd, er, lat);
    chk("lb", rd, 32'hFFFFFFF0);
    access(1'b0, 32'h30, 32'h0, 2'd0, 1'b0, rd, er, lat);
    chk("lbu", rd, 32'h000000F0);
    access(1'b1, 32'h32, 32'h00001234, 2'd1, 1'b0, rd, er, lat);
    access(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("sh_lw", rd, 32'h123400F0);
    access(1'b0, 32'h30, 32'h0, 2'd3, 1'b0, rd, er, lat);
    chk("size3_err", 32'(er), 32'd1);
`endif

    // one-cycle latency instance
    sel = 1'b1;
    access(1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0, rd, er, lat);
    chk("lat1_sw_latency", 32'(lat), 32'd1);
    chk("lat1_sw_err", 32'(er), 32'd0);
    access(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, er, lat);
    chk("lat1_lw_latency", 32'(lat), 32'd1);
    chk("lat1_lw_data", rd, 32'hCAFEF00D);
    sel = 1'b0;
    repeat (3) @(negedge clk);

    // randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) a = 32'($urandom_range(0, BYTES - 1));
      else if (r < 9) a = 32'($urandom_range(BYTES, BYTES + 12));
      else a = $urandom;
      if (r < 5) a = a & ~32'd3;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), rd, er, lat);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
